// File: rtl/axi_s_m.sv
// AXI4-Stream packet source: one newd request emits BURST_LEN beats of
// seed+index on the m_t* channel, honouring tready back-pressure.
module axi_s_m #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              m_aclk,
  input  logic              m_resetn,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic              m_tready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_base;
  logic [CNT_W-1:0]  r_count;
  logic              r_tvalid;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tlast;

  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  assign w_count_nxt = r_count + CNT_W'(1);
  // Zero-extend (or wrap) the beat index so the sum wraps modulo 2^DATA_W.
  assign w_data_nxt  = r_base + DATA_W'(w_count_nxt);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge m_aclk) begin
    if (!m_resetn) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_count  <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (newd) begin
            r_base   <= din;
            r_count  <= '0;
            r_tdata  <= din;
            r_tvalid <= 1'b1;
            r_tlast  <= (BURST_LEN == 1);
            r_state  <= SEND;
          end
        end
        SEND: begin
          // tvalid is always high in SEND, so tready alone marks a transfer.
          if (m_tready) begin
            if (r_count != LAST_IDX) begin
              r_count <= w_count_nxt;
              r_tdata <= w_data_nxt;
              r_tlast <= (w_count_nxt == LAST_IDX);
            end else begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_tvalid = r_tvalid;
  assign m_tdata  = r_tdata;
  assign m_tlast  = r_tlast;

endmodule

// File: tb/tb_axi_s_m.sv
// Self-checking bench for axi_s_m: directed scenarios plus randomized traffic,
// all compared against a beat-queue model of the packet source.
module tb_axi_s_m;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  logic              clk = 1'b0;
  logic              m_resetn;
  logic              newd;
  logic [DATA_W-1:0] din;
  logic              m_tready;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;

  int tests_run    = 0;
  int tests_failed = 0;
  int xfer_count   = 0;

  axi_s_m #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .m_aclk   (clk),
    .m_resetn (m_resetn),
    .newd     (newd),
    .din      (din),
    .m_tready (m_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast)
  );

  always #5 clk = ~clk;

  // Reference model: the packet still to be delivered, as a queue of beats.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             mdl_q[$];
  logic [DATA_W-1:0] mdl_hold = '0;

  function automatic logic exp_valid();
    return mdl_q.size() != 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data();
    return (mdl_q.size() != 0) ? mdl_q[0].data : mdl_hold;
  endfunction

  function automatic logic exp_last();
    return (mdl_q.size() != 0) ? mdl_q[0].last : 1'b0;
  endfunction

  // One rising edge: advance the model with the inputs the DUT just sampled,
  // then move 1 ns past the edge so outputs are settled for comparison.
  task automatic tick();
    @(posedge clk);
    if (m_tvalid === 1'b1 && m_tready === 1'b1) xfer_count++;
    if (m_resetn !== 1'b1) begin
      mdl_q.delete();
      mdl_hold = '0;
    end else if (mdl_q.size() == 0) begin
      if (newd === 1'b1)
        for (int b = 0; b < BURST_LEN; b++)
          mdl_q.push_back('{data: DATA_W'(din + DATA_W'(b)), last: (b == BURST_LEN - 1)});
    end else if (m_tready === 1'b1) begin
      mdl_hold = mdl_q[0].data;
      void'(mdl_q.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    m_resetn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      newd     = 1'($urandom);
      din      = DATA_W'($urandom);
      m_tready = 1'($urandom);
      tick();
      tests_run++;
      if ({m_tvalid, m_tlast, m_tdata} !== {1'b0, 1'b0, {DATA_W{1'b0}}}) begin
        tests_failed++;
        $display("FAIL reset cyc%0d: valid=%b last=%b data=%h, want 0/0/00", i, m_tvalid, m_tlast, m_tdata);
      end
    end
    newd     = 1'b0;
    m_tready = 1'b1;
    m_resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] want;
    newd = 1'b1; din = 8'h24; m_tready = 1'b1;
    for (int i = 0; i < BURST_LEN; i++) begin
      tick();
      newd = 1'b0;
      want = 8'h24 + 8'(i);
      tests_run++;
      if (m_tvalid !== 1'b1 || m_tdata !== want || m_tlast !== (i == BURST_LEN - 1)) begin
        tests_failed++;
        $display("FAIL single beat%0d: valid=%b data=%h last=%b, want 1/%h/%b",
                 i, m_tvalid, m_tdata, m_tlast, want, (i == BURST_LEN - 1));
      end
    end
    tick();
    tests_run++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
      tests_failed++;
      $display("FAIL single end: valid=%b last=%b, want 0/0", m_tvalid, m_tlast);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] seq[6];
    logic              lst[6];
    xfer_count = 0;
    newd = 1'b1; din = 8'h10; m_tready = 1'b1;
    tick();                                   // beat 10 presented
    newd = 1'b0;
    tick();                                   // 10 taken, 11 presented
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h11 || m_tlast !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp stall%0d: valid=%b data=%h last=%b, want 1/11/0", i, m_tvalid, m_tdata, m_tlast);
      end
    end
    m_tready = 1'b1;
    seq = '{8'h12, 8'h13, 8'h13, 8'h13, 8'h13, 8'h13};
    lst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (m_tvalid !== 1'b1 || m_tdata !== seq[i] || m_tlast !== lst[i]) begin
        tests_failed++;
        $display("FAIL bp beat%0d: valid=%b data=%h last=%b, want 1/%h/%b", i, m_tvalid, m_tdata, m_tlast, seq[i], lst[i]);
      end
    end
    tick();
    tick();
    tests_run++;
    if (xfer_count != BURST_LEN || m_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp count: transfers=%0d valid=%b, want %0d/0", xfer_count, m_tvalid, BURST_LEN);
    end
  endtask

  task automatic test_repeat();
    logic [DATA_W-1:0] seeds[7];
    logic [DATA_W-1:0] want;
    for (int p = 0; p < 7; p++) seeds[p] = DATA_W'($urandom);
    newd = 1'b1; m_tready = 1'b1; din = seeds[0];
    for (int p = 0; p < 6; p++) begin
      for (int b = 0; b < BURST_LEN; b++) begin
        tick();
        m_tready = 1'b1;
        want = DATA_W'(seeds[p] + DATA_W'(b));
        tests_run++;
        if (m_tvalid !== 1'b1 || m_tdata !== want || m_tlast !== (b == BURST_LEN - 1)) begin
          tests_failed++;
          $display("FAIL repeat pkt%0d beat%0d: valid=%b data=%h last=%b, want 1/%h/%b",
                   p, b, m_tvalid, m_tdata, m_tlast, want, (b == BURST_LEN - 1));
        end
      end
      tick();                                 // tlast accepted: one idle cycle
      tests_run++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
        tests_failed++;
        $display("FAIL repeat gap%0d: valid=%b last=%b, want 0/0", p, m_tvalid, m_tlast);
      end
      m_tready = 1'bx;                        // ready is a don't-care while idle
      din      = seeds[p+1];
    end
    newd = 1'b0;
    m_tready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] want[4];
    want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    newd = 1'b1; din = 8'hFE; m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      newd = ~newd;
      din  = DATA_W'($urandom);
      tests_run++;
      if (m_tvalid !== 1'b1 || m_tdata !== want[i] || m_tlast !== (i == 3)) begin
        tests_failed++;
        $display("FAIL wrap beat%0d: valid=%b data=%h last=%b, want 1/%h/%b", i, m_tvalid, m_tdata, m_tlast, want[i], (i == 3));
      end
    end
    newd = 1'b0;
    tick();
    tests_run++;
    if (m_tvalid !== 1'b0 || m_tdata !== 8'h01) begin
      tests_failed++;
      $display("FAIL wrap end: valid=%b data=%h, want 0/01", m_tvalid, m_tdata);
    end
  endtask

  task automatic test_mid_reset();
    newd = 1'b1; din = DATA_W'($urandom); m_tready = 1'b1;
    tick();
    newd = 1'b0;
    tick();
    tick();                                   // two beats delivered
    m_resetn = 1'b0;
    tick();
    tests_run++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset: valid=%b last=%b data=%h, want 0/0/00", m_tvalid, m_tlast, m_tdata);
    end
    m_resetn = 1'b1; newd = 1'b1; din = 8'h40;
    for (int i = 0; i < BURST_LEN; i++) begin
      tick();
      newd = 1'b0;
      tests_run++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h40 + 8'(i) || m_tlast !== (i == BURST_LEN - 1)) begin
        tests_failed++;
        $display("FAIL midreset beat%0d: valid=%b data=%h last=%b, want 1/%h/%b",
                 i, m_tvalid, m_tdata, m_tlast, 8'h40 + 8'(i), (i == BURST_LEN - 1));
      end
    end
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      newd     = ($urandom_range(0, 3) != 0);
      din      = DATA_W'($urandom);
      m_tready = ($urandom_range(0, 9) < 7);
      m_resetn = ($urandom_range(0, 99) != 0);
      tick();
      tests_run++;
      if (m_tvalid !== exp_valid() || m_tlast !== exp_last() || m_tdata !== exp_data()) begin
        tests_failed++;
        if (errs++ < 10)
          $display("FAIL random cyc%0d: valid=%b last=%b data=%h, want %b/%b/%h",
                   i, m_tvalid, m_tlast, m_tdata, exp_valid(), exp_last(), exp_data());
      end
    end
    m_resetn = 1'b1;
    newd = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < BURST_LEN + 1; i++) tick();
  endtask

  initial begin
    m_resetn = 1'b0;
    newd     = 1'b0;
    din      = '0;
    m_tready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_repeat();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
